// File: rtl/mem_walk_pkg.sv
// Shared types and constants for the memory-walk FSM: state encoding, mode codes and
// the active-low hex glyph table (bit order gfedcba).
package mem_walk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StWaitRd,
    StCheck,
    StShow,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] MODE_READ    = 2'd0;
  localparam logic [1:0] MODE_WVERIFY = 2'd1;
  localparam logic [1:0] MODE_AUTO    = 2'd2;

  // Entry [n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] SegTable = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

endpackage

// File: rtl/mem_walk_fsm_hex_to_7seg.sv
// One hex digit to an active-low seven-segment glyph.
module hex_to_7seg
  import mem_walk_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SegTable[hex_i];

endmodule

// File: rtl/mem_walk_fsm.sv
// Steps through a synchronous RAM on debounced button presses or sweeps it automatically,
// optionally writing an address-derived pattern and verifying the read-back.
module mem_walk_fsm
  import mem_walk_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned NUM_ADDR        = 1024,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SEED            = 32'hA5C3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [9:0]        leds,
  output logic [13:0]       left_7_seg_pair,
  output logic [13:0]       right_7_seg_pair
);

  localparam int unsigned DbW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_ADDR - 1);
  localparam logic [1:0] LatLast    = 2'(READ_LATENCY - 1);
  localparam logic [DATA_W-1:0] SeedW = DATA_W'(SEED);

  // Button: 2-FF synchroniser, then a level accepted only after DbLast+1 stable cycles.
  logic           sync1_q, sync2_q, db_level_q, press_q;
  logic [DbW-1:0] db_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q <= advance;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        db_level_q <= sync2_q;
        db_cnt_q   <= '0;
        press_q    <= ~sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [DATA_W-1:0] data_q, data_d, pat;
  logic              err_q, err_d, done_q, done_d;
  logic [1:0]        mode_q, mode_d, wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_READ;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
    end
  end

  assign pat       = DATA_W'(addr_q) ^ SeedW;
  assign next_addr = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = done_q;
    mode_d  = mode_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (press_q) begin
          mode_d  = (mode == 2'd3) ? MODE_READ : mode;
          state_d = (mode == MODE_WVERIFY) ? StWrite : StRead;
        end
      end
      StWrite: state_d = StRead;
      StRead: begin
        wait_d  = '0;
        state_d = StWaitRd;
      end
      StWaitRd: begin
        if (wait_q == LatLast) begin
          data_d  = mem_rdata;
          state_d = StCheck;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCheck: begin
        if (mode_q == MODE_WVERIFY && data_q != pat) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          state_d = StShow;
        end
      end
      StShow: begin
        if (mode_q == MODE_AUTO) begin
          if (addr_q == LastAddr) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRead;
          end
        end else if (press_q) begin
          addr_d  = next_addr;
          state_d = (mode_q == MODE_WVERIFY) ? StWrite : StRead;
        end
      end
      StDone: begin
        if (press_q) begin
          done_d  = 1'b0;
          addr_d  = '0;
          state_d = StIdle;
        end
      end
      StErr: ;  // held until reset
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from the state register so a reset edge drops them at once.
  assign mem_we    = (state_q == StWrite);
  assign mem_re    = (state_q == StRead);
  assign mem_wdata = mem_we ? pat : '0;
  assign mem_addr  = addr_q;
  assign leds      = {err_q, done_q, mode_q, data_q[5:0]};

  hex_to_7seg u_seg_addr_hi (.hex_i(addr_q[7:4]), .seg_o(left_7_seg_pair[13:7]));
  hex_to_7seg u_seg_addr_lo (.hex_i(addr_q[3:0]), .seg_o(left_7_seg_pair[6:0]));
  hex_to_7seg u_seg_data_hi (.hex_i(data_q[7:4]), .seg_o(right_7_seg_pair[13:7]));
  hex_to_7seg u_seg_data_lo (.hex_i(data_q[3:0]), .seg_o(right_7_seg_pair[6:0]));

endmodule

// File: tb/tb_mem_walk_fsm.sv
// Randomised scoreboard bench for mem_walk_fsm with a behavioural RAM and reference model.
module tb_mem_walk_fsm;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 10;
  localparam int unsigned NA   = 8;
  localparam int unsigned RL   = 2;
  localparam int unsigned DEB  = 2;
  localparam logic [15:0] SEED = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset, advance;
  logic [1:0]    mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic [9:0]    leds;
  logic [13:0]   left_7_seg_pair, right_7_seg_pair;

  always #5 clk = ~clk;

  mem_walk_fsm #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_ADDR(NA), .READ_LATENCY(RL),
    .DEBOUNCE_CYCLES(DEB), .SEED(32'(SEED))
  ) dut (
    .clk(clk), .reset(reset), .advance(advance), .mode(mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .leds(leds),
    .left_7_seg_pair(left_7_seg_pair), .right_7_seg_pair(right_7_seg_pair)
  );

  // RAM with two-cycle read latency; stuck_en forces bit 0 of address 1 high on reads.
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] rd1, rd2;
  logic          stuck_en, pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) rd1 <= ram[mem_addr] | ((stuck_en && mem_addr == 10'd1) ? 16'h0001 : 16'h0000);
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [13:0] pair(input logic [7:0] b);
    return {seg_of(b[7:4]), seg_of(b[3:0])};
  endfunction

  // Scoreboard: expected RAM transactions queued by the stimulus, popped by the monitor.
  logic [AW-1:0]    exp_rd_q [$];
  logic [AW+DW-1:0] exp_wr_q [$];

  always @(negedge clk) begin
    if (mem_we || mem_re) check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    if (mem_re) begin
      if (exp_rd_q.size() == 0) check("unexpected_read_addr", 32'(mem_addr), 32'hFFFF_FFFF);
      else check("read_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
    end
    if (mem_we) begin
      if (exp_wr_q.size() == 0) check("unexpected_write", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
      else check("write_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q.pop_front()));
    end
  end

  logic [DW-1:0] ref_mem [NA];
  int unsigned   m_addr;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    advance = 1'b0;
    tick(hold);
    advance = 1'b1;
    tick(10);
  endtask

  task automatic do_reset();
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_leds"}, 32'(leds), 32'd0);
    check({tag, "_left"}, 32'(left_7_seg_pair), 32'(14'b1000000_1000000));
    check({tag, "_right"}, 32'(right_7_seg_pair), 32'(14'b1000000_1000000));
    check({tag, "_strobes"}, 32'({mem_we, mem_re}), 32'd0);
  endtask

  task automatic check_show(input string tag, input int unsigned a);
    check({tag, "_addr"}, 32'(mem_addr), 32'(a));
    check({tag, "_left"}, 32'(left_7_seg_pair), 32'(pair(8'(a))));
    check({tag, "_right"}, 32'(right_7_seg_pair), 32'(pair(ref_mem[a][7:0])));
    check({tag, "_leds_data"}, 32'(leds[5:0]), 32'(ref_mem[a][5:0]));
  endtask

  initial begin
    logic [DW-1:0] pv;
    bit            seen;
    reset = 1'b0; advance = 1'b1; mode = 2'd0; stuck_en = 1'b0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    tick(2);
    for (int i = 0; i < int'(NA); i++) begin
      pv = (i == 0) ? 16'h1234 : (i == 1) ? 16'h00AB : 16'($urandom);
      ref_mem[i] = pv;
      pl_we = 1'b1; pl_addr = AW'(i); pl_data = pv;
      tick(1);
    end
    pl_we = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    check_reset_outputs("reset");

    // Read walk with a long hold on the first press, then random holds through the wrap.
    mode = 2'd0;
    m_addr = 0;
    exp_rd_q.push_back(AW'(m_addr));
    press(40);
    tick(20);
    check_show("walk_first", m_addr);
    check("walk_right_34", 32'(right_7_seg_pair), 32'(pair(8'h34)));
    for (int k = 1; k <= int'(NA); k++) begin
      m_addr = (m_addr + 1) % NA;
      exp_rd_q.push_back(AW'(m_addr));
      mode = 2'($urandom_range(0, 3));  // ignored outside IDLE
      press(6 + int'($urandom_range(0, 20)));
      tick(20);
      check_show("walk", m_addr);
      check("walk_mode_leds", 32'(leds[7:6]), 32'd0);
    end
    do_reset();
    check("reset_mode_leds", 32'(leds[7:6]), 32'd0);

    // Write-verify over the first three addresses.
    mode = 2'd1;
    for (int k = 0; k < 3; k++) begin
      pv = 16'(k) ^ SEED;
      ref_mem[k] = pv;
      exp_wr_q.push_back({AW'(k), pv});
      exp_rd_q.push_back(AW'(k));
      press(8);
      tick(20);
      check_show("wverify", k);
      check("wverify_err", 32'(leds[9]), 32'd0);
      check("wverify_mode_leds", 32'(leds[7:6]), 32'd1);
    end
    check("wverify_last_c1", 32'(right_7_seg_pair), 32'(pair(8'hC1)));
    do_reset();

    // Write-verify with a faulty bit at address 1: must lock in the error state.
    stuck_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_wr_q.push_back({AW'(k), 16'(k) ^ SEED});
      exp_rd_q.push_back(AW'(k));
      press(8);
      tick(20);
    end
    check("err_led", 32'(leds[9]), 32'd1);
    check("err_left", 32'(left_7_seg_pair), 32'(pair(8'h01)));
    check("err_right", 32'(right_7_seg_pair), 32'(pair(8'hC3)));
    press(8);
    mode = 2'd2;
    press(8);
    tick(10);
    check("err_hold_addr", 32'(mem_addr), 32'd1);
    check("err_hold_leds", 32'(leds), 32'({1'b1, 1'b0, 2'b01, 6'h03}));
    check("err_hold_right", 32'(right_7_seg_pair), 32'(pair(8'hC3)));
    stuck_en = 1'b0;
    do_reset();

    // Automatic sweep across every address.
    mode = 2'd2;
    for (int k = 0; k < int'(NA); k++) exp_rd_q.push_back(AW'(k));
    press(6);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (leds[8]) seen = 1'b1;
      else tick(1);
    end
    check("auto_done_seen", 32'(seen), 32'd1);
    tick(3);
    check_show("auto_end", NA - 1);
    check("auto_mode_leds", 32'(leds[7:6]), 32'd2);
    press(6);
    tick(5);
    check("done_cleared", 32'(leds[8]), 32'd0);
    check("done_addr0", 32'(mem_addr), 32'd0);
    // Back in IDLE: a read-walk press starts again at address 0.
    mode = 2'd0;
    exp_rd_q.push_back(AW'(0));
    press(6);
    tick(20);
    check_show("after_done", 0);

    // Reset landing while a read is outstanding.
    m_addr = 1;
    exp_rd_q.push_back(AW'(m_addr));
    advance = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick(1);
      if (mem_re) seen = 1'b1;
    end
    check("midread_re_seen", 32'(seen), 32'd1);
    tick(1);
    reset = 1'b0;
    tick(1);
    check_reset_outputs("midread_reset");
    advance = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(5);
    check("final_rd_queue", 32'(exp_rd_q.size()), 32'd0);
    check("final_wr_queue", 32'(exp_wr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
